// File: rtl/and3_vector_checker.sv
// Stimulus generator and response checker for a 3-input AND block: sweeps all 8 vectors and counts mismatches.
// Optional build macro STOP_ON_FAIL_EN ends the run on the first mismatch.
module and3_vector_checker #(
  parameter int DWELL      = 200,
  parameter int NUM_PASSES = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             vec_a,
  output logic             vec_b,
  output logic             vec_c,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fail_vec,
  output logic             fail_seen
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
  localparam logic [PW-1:0]    PASS_LAST  = PW'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       idx_r, idx_s;
  logic [DW-1:0]    dwell_r, dwell_s;
  logic [PW-1:0]    pcnt_r, pcnt_s;
  logic [ERR_W-1:0] err_r, err_s;
  logic [2:0]       fvec_r, fvec_s;
  logic             fseen_r, fseen_s;
  logic [2:0]       vec_r, vec_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic             mismatch_s;

  // Next-state, counters and mismatch bookkeeping
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    dwell_s    = dwell_r;
    pcnt_s     = pcnt_r;
    err_s      = err_r;
    fvec_s     = fvec_r;
    fseen_s    = fseen_r;
    mismatch_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = RUN;
          idx_s   = 3'd0;
          dwell_s = '0;
          pcnt_s  = '0;
          err_s   = '0;
          fvec_s  = 3'd0;
          fseen_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (dwell_r == DWELL_LAST) begin
          // vec_r always equals idx_r while running, so it is the vector being sampled
          mismatch_s = (dut_y != (vec_r[2] & vec_r[1] & vec_r[0]));
          dwell_s    = '0;
          if (mismatch_s) begin
            if (err_r != ERR_MAX) begin
              err_s = err_r + ERR_W'(1);
            end else begin
              err_s = err_r;
            end
            if (!fseen_r) begin
              fvec_s  = vec_r;
              fseen_s = 1'b1;
            end else begin
              fvec_s = fvec_r;
            end
          end else begin
            err_s = err_r;
          end
          if ((idx_r == 3'd7) && (pcnt_r == PASS_LAST)) begin
            state_s = DONE;
          end else begin
            idx_s = idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              pcnt_s = pcnt_r + PW'(1);
            end else begin
              pcnt_s = pcnt_r;
            end
          end
`ifdef STOP_ON_FAIL_EN
          if (mismatch_s) begin
            state_s = DONE;
          end else begin
            state_s = state_s;
          end
`endif
        end else begin
          dwell_s = dwell_r + DW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered outputs follow the next state so they line up with it
  always_comb begin
    vec_s  = (state_s == RUN) ? idx_s : 3'd0;
    busy_s = (state_s == RUN);
    done_s = (state_s == DONE);
    pass_s = done_s && (err_s == '0);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
      dwell_r <= '0;
      pcnt_r  <= '0;
      err_r   <= '0;
      fvec_r  <= 3'd0;
      fseen_r <= 1'b0;
      vec_r   <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      dwell_r <= dwell_s;
      pcnt_r  <= pcnt_s;
      err_r   <= err_s;
      fvec_r  <= fvec_s;
      fseen_r <= fseen_s;
      vec_r   <= vec_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  assign vec_a     = vec_r[2];
  assign vec_b     = vec_r[1];
  assign vec_c     = vec_r[0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
  assign fail_vec  = fvec_r;
  assign fail_seen = fseen_r;

endmodule

// File: tb/tb_and3_vector_checker.sv
// Bench for and3_vector_checker: four checker configurations, each wired to an emulated AND block
// whose fault mode (good, stuck-at-0, stuck-at-1) is selected per test.
module tb_and3_vector_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start_v = 4'b0000;
  int         mode = 0;
  int         sel = 0;
  int         checks = 0;
  int         errors = 0;

`ifdef STOP_ON_FAIL_EN
  localparam bit SOF = 1'b1;
`else
  localparam bit SOF = 1'b0;
`endif

  always #5 clk = ~clk;

  // Emulated block under check: 0 good AND, 1 stuck-at-0, 2 stuck-at-1
  function automatic logic dev_y(input int m, input logic a, input logic b, input logic c);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      default: return a & b & c;
    endcase
  endfunction

  logic va0, vb0, vc0, y0, b0, d0, p0, s0; logic [7:0] e0; logic [2:0] f0;
  logic va1, vb1, vc1, y1, b1, d1, p1, s1; logic [7:0] e1; logic [2:0] f1;
  logic va2, vb2, vc2, y2, b2, d2, p2, s2; logic [2:0] e2; logic [2:0] f2;
  logic va3, vb3, vc3, y3, b3, d3, p3, s3; logic [7:0] e3; logic [2:0] f3;

  assign y0 = dev_y(mode, va0, vb0, vc0);
  assign y1 = dev_y(mode, va1, vb1, vc1);
  assign y2 = dev_y(mode, va2, vb2, vc2);
  assign y3 = dev_y(mode, va3, vb3, vc3);

  and3_vector_checker #(.DWELL(4), .NUM_PASSES(1), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .vec_a(va0), .vec_b(vb0), .vec_c(vc0), .dut_y(y0),
    .busy(b0), .done(d0), .pass(p0), .err_count(e0), .fail_vec(f0), .fail_seen(s0));
  and3_vector_checker #(.DWELL(2), .NUM_PASSES(2), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .vec_a(va1), .vec_b(vb1), .vec_c(vc1), .dut_y(y1),
    .busy(b1), .done(d1), .pass(p1), .err_count(e1), .fail_vec(f1), .fail_seen(s1));
  and3_vector_checker #(.DWELL(2), .NUM_PASSES(2), .ERR_W(3)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .vec_a(va2), .vec_b(vb2), .vec_c(vc2), .dut_y(y2),
    .busy(b2), .done(d2), .pass(p2), .err_count(e2), .fail_vec(f2), .fail_seen(s2));
  and3_vector_checker #(.DWELL(1), .NUM_PASSES(1), .ERR_W(8)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .vec_a(va3), .vec_b(vb3), .vec_c(vc3), .dut_y(y3),
    .busy(b3), .done(d3), .pass(p3), .err_count(e3), .fail_vec(f3), .fail_seen(s3));

  logic [2:0] m_vec, m_fvec;
  logic       m_busy, m_done, m_pass, m_fseen;
  logic [7:0] m_err;

  // Route the instance under test onto one set of monitor signals
  always_comb begin
    m_vec = {va0, vb0, vc0}; m_busy = b0; m_done = d0; m_pass = p0; m_err = e0; m_fvec = f0; m_fseen = s0;
    case (sel)
      1: begin m_vec = {va1, vb1, vc1}; m_busy = b1; m_done = d1; m_pass = p1; m_err = e1; m_fvec = f1; m_fseen = s1; end
      2: begin m_vec = {va2, vb2, vc2}; m_busy = b2; m_done = d2; m_pass = p2; m_err = {5'd0, e2}; m_fvec = f2; m_fseen = s2; end
      3: begin m_vec = {va3, vb3, vc3}; m_busy = b3; m_done = d3; m_pass = p3; m_err = e3; m_fvec = f3; m_fseen = s3; end
      default: begin end
    endcase
  end

  typedef struct {
    int         k;
    int         mode;
    int         dwell;
    int         exp_busy;
    int         exp_err;
    logic [2:0] exp_fvec;
    logic       exp_fseen;
    logic       exp_pass;
  } vec_t;

  vec_t       tbl [6];
  logic [2:0] sb_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vec"}, int'(m_vec), 0);
    chk({tag, "_busy"}, int'(m_busy), 0);
    chk({tag, "_done"}, int'(m_done), 0);
    chk({tag, "_pass"}, int'(m_pass), 0);
    chk({tag, "_err"}, int'(m_err), 0);
    chk({tag, "_fvec"}, int'(m_fvec), 0);
    chk({tag, "_fseen"}, int'(m_fseen), 0);
  endtask

  // One run: push the expected vector per busy cycle, pop and compare as the checker drives them
  task automatic run(input vec_t e, input int glitch_at, input string tag);
    int n = 0;
    int cyc = 0;
    logic [2:0] exp_v;
    sel = e.k;
    mode = e.mode;
    sb_q.delete();
    for (int i = 0; i < e.exp_busy; i++) sb_q.push_back(3'((i / e.dwell) % 8));
    @(negedge clk);
    start_v[e.k] = 1'b1;
    @(negedge clk);
    start_v[e.k] = 1'b0;
    while (!m_done && cyc < 2000) begin
      start_v[e.k] = (n == glitch_at) && m_busy;
      if (m_busy) begin
        if (sb_q.size() > 0) begin
          exp_v = sb_q.pop_front();
          chk({tag, "_vec"}, int'(m_vec), int'(exp_v));
        end else begin
          chk({tag, "_busy_overrun"}, n, e.exp_busy - 1);
        end
        chk({tag, "_pass_while_busy"}, int'(m_pass), 0);
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    start_v[e.k] = 1'b0;
    chk({tag, "_done"}, int'(m_done), 1);
    chk({tag, "_busy_cycles"}, n, e.exp_busy);
    chk({tag, "_sb_left"}, sb_q.size(), 0);
    chk({tag, "_busy_at_done"}, int'(m_busy), 0);
    chk({tag, "_err"}, int'(m_err), e.exp_err);
    chk({tag, "_fvec"}, int'(m_fvec), int'(e.exp_fvec));
    chk({tag, "_fseen"}, int'(m_fseen), int'(e.exp_fseen));
    chk({tag, "_pass"}, int'(m_pass), int'(e.exp_pass));
    chk({tag, "_vec_idle"}, int'(m_vec), 0);
  endtask

  initial begin
    //          k  mode dwell busy               err               fvec  fseen pass
    tbl[0] = '{0, 0, 4, 32,                0,                3'd0, 1'b0, 1'b1};
    tbl[1] = '{0, 1, 4, 32,                1,                3'd7, 1'b1, 1'b0};
    tbl[2] = '{1, 2, 2, SOF ? 2 : 32,      SOF ? 1 : 14,     3'd0, 1'b1, 1'b0};
    tbl[3] = '{2, 2, 2, SOF ? 2 : 32,      SOF ? 1 : 7,      3'd0, 1'b1, 1'b0};
    tbl[4] = '{3, 0, 1, 8,                 0,                3'd0, 1'b0, 1'b1};
    tbl[5] = '{0, 2, 4, SOF ? 4 : 32,      SOF ? 1 : 7,      3'd0, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run(tbl[i], -1, $sformatf("t%0d", i));

    // Reset mid-run during vector 3, with start asserted in the same cycle
    sel = 0;
    mode = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (13) @(negedge clk);
    chk("midrun_vec", int'(m_vec), 3);
    chk("midrun_busy", int'(m_busy), 1);
    rst = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_v[0] = 1'b0;
    chk_idle("midrun_rst");
    @(negedge clk);
    chk("rst_start_ignored", int'(m_busy), 0);

    // Fresh run after reset, with a stray start pulse while busy
    run(tbl[0], 5, "restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
